// File: rtl/uart_term_pkg.sv
// Shared ASCII constants, receiver FSM states and helpers for the
// terminal UART receiver.
package uart_term_pkg;

    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;
    localparam logic [7:0] ASCII_DEL      = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    function automatic logic is_term_char(input logic [7:0] c);
        return ((c >= ASCII_PRINT_LO) && (c <= ASCII_PRINT_HI))
            || (c == ASCII_CR);
    endfunction

    // Rounded clock divider for one oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud,
                                    input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_term_fifo.sv
// First-word fall-through character FIFO; full-with-pop is accepted,
// full-without-pop drops the push and flags it for one cycle.
module uart_term_fifo
    import uart_term_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_ready && !w_empty;
    assign w_wr    = i_push && (!w_full || w_pop);

    assign o_drop  = i_push && w_full && !w_pop;
    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst_n && w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_term_rx.sv
// Oversampling UART receiver with terminal-character filter and FIFO.
// Define UART_TERM_BS_EN to also accept BS and map DEL to BS.
module uart_term_rx
    import uart_term_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    char_o,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [OW-1:0] OS_HALF  = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_term_rx: clock divider below 2");
    end
    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_os
        $error("uart_term_rx: OVERSAMPLE must be even and >= 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_term_rx: FIFO_DEPTH must be a power of 2 >= 2");
    end

    logic r_rx_s1;
    logic r_rx_s2;
    logic r_rx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    rx_state_t        r_state;
    logic [DW-1:0]    r_div_cnt;
    logic [OW-1:0]    r_os_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_byte_done;
    logic             r_ferr;
    logic             r_err_wait;

    logic w_tick;
    logic w_fall;
    logic w_start;

    assign w_tick  = (r_div_cnt == DIV_LAST);
    assign w_fall  = r_rx_d && !r_rx_s2;
    assign w_start = (r_state == ST_IDLE) && w_fall;

    // A new frame realigns the tick phase to its falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n || w_start || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_byte_done <= 1'b0;
            r_ferr      <= 1'b0;
            r_err_wait  <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_ferr      <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state  <= ST_START;
                        r_os_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_HALF) begin
                            r_os_cnt  <= '0;
                            r_bit_cnt <= '0;
                            r_state   <= r_rx_s2 ? ST_IDLE : ST_DATA;
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt  <= '0;
                            r_shift   <= {r_rx_s2, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_err_wait) begin
                            if (r_rx_s2) begin
                                r_err_wait <= 1'b0;
                                r_state    <= ST_IDLE;
                            end
                        end else if (r_os_cnt == OS_LAST) begin
                            r_os_cnt <= '0;
                            if (r_rx_s2) begin
                                r_byte_done <= 1'b1;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_ferr     <= 1'b1;
                                r_err_wait <= 1'b1;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    logic       w_accept;
    logic [7:0] w_mapped;

`ifdef UART_TERM_BS_EN
    assign w_accept = is_term_char(r_shift) || (r_shift == ASCII_BS)
                   || (r_shift == ASCII_DEL);
    assign w_mapped = (r_shift == ASCII_DEL) ? ASCII_BS : r_shift;
`else
    assign w_accept = is_term_char(r_shift);
    assign w_mapped = r_shift;
`endif

    logic       r_push;
    logic [7:0] r_push_data;
    logic       r_overflow;
    logic       w_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push      <= r_byte_done && w_accept;
            r_push_data <= w_mapped;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    uart_term_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .i_ready (ready),
        .o_data  (char_o),
        .o_valid (valid),
        .o_count (count),
        .o_drop  (w_drop)
    );

    assign frame_err = r_ferr;
    assign overflow  = r_overflow;

endmodule

// File: doc/uart_term_rx.md
UART_TERM_RX -- requirements
Module: uart_term_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, the line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, the sample ticks per bit; it SHALL be even and at least 8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, the character buffer entries; it SHALL be a power of 2 and at least 2.
REQ-005 SHALL have port clk, input, width 1, the single system clock.
REQ-006 SHALL have port rst_n, input, width 1, a synchronous active-low reset.
REQ-007 SHALL have port rx, input, width 1, the asynchronous serial line (idle high).
REQ-008 SHALL have port char_o, output, width 8, the head-of-FIFO character.
REQ-009 SHALL have port valid, output, width 1, asserted while the FIFO is non-empty.
REQ-010 SHALL have port ready, input, width 1, the consumer accept; a pop occurs when valid && ready.
REQ-011 SHALL have port count, output, width $clog2(FIFO_DEPTH)+1, the current FIFO occupancy.
REQ-012 SHALL have port frame_err, output, width 1, a one-cycle pulse per bad stop bit.
REQ-013 SHALL have port overflow, output, width 1, sticky, set when an accepted character is dropped.
REQ-014 SHALL have port ovf_clr, input, width 1, which clears overflow.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-016 SHALL emit a tick every DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)) clk cycles, with the counter running 0..DIV-1 and wrapping.
REQ-017 SHALL implement the FSM states IDLE, START, DATA and STOP, with transitions on ticks only except IDLE->START.
REQ-018 SHALL move IDLE->START on a synchronized falling edge and reset the tick phase to 0.
REQ-019 SHALL sample START at tick OVERSAMPLE/2, going high->IDLE (glitch rejected) or low->DATA.
REQ-020 SHALL sample DATA every OVERSAMPLE ticks, 8 bits, LSB first, then go to STOP.
REQ-021 SHALL sample STOP mid-bit: on 1 it raises byte_done for one cycle; on 0 it pulses frame_err for one cycle, discards the byte, and waits for rx=1 before IDLE.
REQ-022 SHALL apply the filter: accept 0x20..0x7E and 0x0D; drop all other codes silently.
REQ-023 SHALL push an accepted byte into the FIFO the cycle after byte_done, and valid/char_o SHALL update the following cycle (first-word fall-through, no bypass).
REQ-024 SHALL treat push while full without a simultaneous pop as follows: the byte is dropped, overflow is set, and the contents are unchanged.
REQ-025 SHALL treat push while full with a simultaneous pop as follows: both occur, count is unchanged, and there is no overflow.
REQ-026 SHALL ignore ready while empty, with no underflow and no pointer change.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH, and count SHALL equal writes minus reads.
REQ-028 SHALL clear overflow on ovf_clr; if a set and a clear occur in the same cycle, the set wins.

Reset
REQ-029 SHALL, while rst_n=0 at a clk edge, go to IDLE and clear the tick counter, pointers, count, valid, frame_err and overflow, and set char_o=0x00.
REQ-030 SHALL discard any partial frame on reset mid-frame; after release the receiver SHALL wait for a fresh falling edge.
REQ-031 SHALL initialise synchronizer flops to 1 on reset.

Configuration
REQ-032 SHALL, with macro UART_TERM_BS_EN defined, additionally accept 0x08 and map 0x7F to 0x08 before push.
REQ-033 SHALL, without UART_TERM_BS_EN, drop 0x08 and 0x7F per REQ-022.

Structure
REQ-034 SHALL place ASCII constants (CR, BS, DEL, printable bounds) and the FSM state enum in package uart_term_pkg.
REQ-035 SHALL implement the FIFO as the single sub-module uart_term_fifo, parameterised by DEPTH and WIDTH=8.
REQ-036 SHALL check parameters at elaboration, failing if DIV<2, OVERSAMPLE is odd, or FIFO_DEPTH is not a power of 2.

Verification
All scenarios run at CLK_HZ=100e6, BAUD=115200, DIV=54.
REQ-037 SHALL verify: send 0x41 with ready=1 -> char_o=0x41 and valid high exactly one cycle, count 1->0.
REQ-038 SHALL verify: send 0x0A then 0x0D -> 0x0A produces no valid, 0x0D delivered.
REQ-039 SHALL verify: send 0x55 with stop bit=0 -> one frame_err pulse, count stays 0; next good 0x42 is delivered.
REQ-040 SHALL verify: ready=0, send 'a'..'q' (17 bytes) -> count=16, overflow=1; drain yields 'a'..'p' in order; ovf_clr clears overflow.
REQ-041 SHALL verify: a 3-tick low glitch on idle rx, then rst_n pulsed mid-DATA of 0x33 -> no character and no frame_err; the next 0x34 is delivered.
REQ-042 SHALL verify: send 0x7F -> char_o=0x08 with UART_TERM_BS_EN defined, no valid without it.
